// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequencing controller for a simple fetch/execute core.
// It walks an external program counter through instruction fetch and
// execute. It handles branches with a range check, halt instructions,
// the end-of-program PC and instruction-memory acknowledge timeouts,
// and it counts retired instructions.
module fetch_ctrl #(
  parameter int LAST_PC     = 63,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        init_n,
  input  logic        start,
  input  logic [9:0]  pc,
  input  logic        imem_ack,
  input  logic        halt_instr,
  input  logic        br_take,
  input  logic        br_sign,
  input  logic [7:0]  br_off,
  output logic        pc_init,
  output logic        pc_branch_en,
  output logic        pc_bsign,
  output logic [7:0]  pc_boffset,
  output logic        imem_req,
  output logic        ir_load,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [15:0] instr_cnt
);

  localparam int WAIT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
  localparam logic [9:0]        LAST_PC_U = 10'(LAST_PC);
  localparam logic signed [10:0] LAST_PC_S = $signed(11'(LAST_PC));

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    HALTED = 3'd3,
    FAULT  = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic signed [10:0] br_target;
  logic               br_in_range;
  logic               ack_timeout;

  // Branch target is formed one bit wider than pc so that underflow
  // below zero shows up as a negative value instead of wrapping.
  assign br_target   = br_sign ? ($signed({1'b0, pc}) - $signed({3'b000, br_off}))
                               : ($signed({1'b0, pc}) + $signed({3'b000, br_off}));
  assign br_in_range = (br_target >= 11'sd0) && (br_target <= LAST_PC_S);
  assign ack_timeout = (wait_cnt == WAIT_LAST);

  // State register; reset drops straight back to IDLE without a clock.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Counts FETCH cycles spent without an acknowledge; zero outside FETCH,
  // so every entry into FETCH starts a fresh wait.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n)                          wait_cnt <= '0;
    else if (state == FETCH && !imem_ack) wait_cnt <= wait_cnt + 1'b1;
    else                                  wait_cnt <= '0;
  end

  // Retired-instruction counter: cleared on start from IDLE, bumped on every
  // EXEC exit, and it sticks at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n)                                  instr_cnt <= 16'd0;
    else if (state == IDLE && start)              instr_cnt <= 16'd0;
    else if (state == EXEC && instr_cnt != 16'hFFFF) instr_cnt <= instr_cnt + 16'd1;
  end

  // Next-state and control decode. "Hold" is branch_en with a zero offset,
  // which freezes the otherwise free-running program counter.
  always_comb begin
    state_nxt    = state;
    pc_init      = 1'b0;
    pc_branch_en = 1'b0;
    pc_bsign     = 1'b0;
    pc_boffset   = 8'd0;
    imem_req     = 1'b0;
    ir_load      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    fault        = 1'b0;
    case (state)
      IDLE: begin
        pc_init = 1'b1;
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        imem_req     = 1'b1;
        busy         = 1'b1;
        pc_branch_en = 1'b1;
        if (imem_ack) begin
          ir_load   = 1'b1;
          state_nxt = EXEC;
        end else if (ack_timeout) begin
          state_nxt = FAULT;
        end
      end
      EXEC: begin
        busy = 1'b1;
        if (halt_instr) begin
          pc_branch_en = 1'b1;
          state_nxt    = HALTED;
        end else if (br_take) begin
          pc_branch_en = 1'b1;
          if (br_in_range) begin
            pc_bsign   = br_sign;
            pc_boffset = br_off;
            state_nxt  = FETCH;
          end else begin
            state_nxt  = FAULT;
          end
        end else if (pc == LAST_PC_U) begin
          pc_branch_en = 1'b1;
          state_nxt    = HALTED;
        end else begin
          state_nxt = FETCH;
        end
      end
      HALTED: begin
        done         = 1'b1;
        pc_branch_en = 1'b1;
        if (start) state_nxt = IDLE;
      end
      FAULT: begin
        fault        = 1'b1;
        pc_branch_en = 1'b1;
        if (start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: drives fetch_ctrl with an instruction-level program (per
// fetched instruction: ack latency and decode results) and a behavioural
// program counter, and scoreboards fetch addresses and end-of-run results.
module tb_fetch_ctrl;

  localparam int LAST_PC = 63;
  localparam int ACK_TO  = 15;
  localparam int MAXI    = 80;

  logic        CLK = 1'b0;
  logic        init_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  pc = 10'd0;
  logic        imem_ack = 1'b0;
  logic        halt_instr = 1'b0;
  logic        br_take = 1'b0;
  logic        br_sign = 1'b0;
  logic [7:0]  br_off = 8'd0;
  logic        pc_init, pc_branch_en, pc_bsign;
  logic [7:0]  pc_boffset;
  logic        imem_req, ir_load, busy, done, fault;
  logic [15:0] instr_cnt;

  fetch_ctrl #(.LAST_PC(LAST_PC), .ACK_TIMEOUT(ACK_TO)) dut (
    .CLK(CLK), .init_n(init_n), .start(start), .pc(pc), .imem_ack(imem_ack),
    .halt_instr(halt_instr), .br_take(br_take), .br_sign(br_sign), .br_off(br_off),
    .pc_init(pc_init), .pc_branch_en(pc_branch_en), .pc_bsign(pc_bsign),
    .pc_boffset(pc_boffset), .imem_req(imem_req), .ir_load(ir_load), .busy(busy),
    .done(done), .fault(fault), .instr_cnt(instr_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit       halt;
    bit       br;
    bit       sign;
    bit [7:0] off;
    int       delay;
  } instr_t;

  typedef struct {
    int kind;   // 1 = halted, 2 = fault
    int pc;
    int cnt;
  } term_t;

  instr_t prog [MAXI];
  int     exp_fetch [$];
  term_t  exp_term [$];
  term_t  last_term;
  int     fi = 0;
  int     fcyc = 0;
  int     vectors = 0;
  int     miscompares = 0;
  bit     prev_done = 1'b0;
  bit     prev_fault = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: walks the program one instruction at a time.
  function automatic void model();
    int p = 0;
    int c = 0;
    int t;
    for (int k = 0; k < MAXI; k++) begin
      if (prog[k].delay >= ACK_TO) begin
        last_term = '{2, p, c};
        exp_term.push_back(last_term);
        return;
      end
      exp_fetch.push_back(p);
      c++;
      if (prog[k].halt) begin
        last_term = '{1, p, c};
        exp_term.push_back(last_term);
        return;
      end
      if (prog[k].br) begin
        t = prog[k].sign ? p - int'(prog[k].off) : p + int'(prog[k].off);
        if (t < 0 || t > LAST_PC) begin
          last_term = '{2, p, c};
          exp_term.push_back(last_term);
          return;
        end
        p = t;
      end else if (p == LAST_PC) begin
        last_term = '{1, p, c};
        exp_term.push_back(last_term);
        return;
      end else begin
        p++;
      end
    end
    last_term = '{0, 0, 0};
  endfunction

  function automatic void clear_prog();
    for (int k = 0; k < MAXI; k++) prog[k] = '{1'b0, 1'b0, 1'b0, 8'd0, 0};
  endfunction

  function automatic void random_prog();
    for (int k = 0; k < MAXI; k++) begin
      prog[k].halt  = ($urandom_range(0, 39) == 0);
      prog[k].br    = ($urandom_range(0, 5) == 0);
      prog[k].sign  = 1'($urandom_range(0, 1));
      prog[k].off   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(0, 12));
      prog[k].delay = ($urandom_range(0, 24) == 0) ? (($urandom_range(0, 1) == 0) ? 14 : 20)
                                                   : int'($urandom_range(0, 2));
    end
    prog[MAXI-1].halt = 1'b1;
  endfunction

  // One clock: drive inputs at the falling edge, step the program counter
  // model shortly after the rising edge.
  task automatic step(input bit st);
    logic [9:0] pcn;
    int fin, fcn;
    @(negedge CLK);
    start = st | (busy && ($urandom_range(0, 3) == 0));
    if (imem_req) imem_ack = (fi < MAXI) && (fcyc == prog[fi].delay);
    else          imem_ack = 1'($urandom_range(0, 1));
    if (busy && !imem_req && fi > 0 && fi <= MAXI) begin
      halt_instr = prog[fi-1].halt;
      br_take    = prog[fi-1].br;
      br_sign    = prog[fi-1].sign;
      br_off     = prog[fi-1].off;
    end else begin
      halt_instr = 1'($urandom_range(0, 1));
      br_take    = 1'($urandom_range(0, 1));
      br_sign    = 1'($urandom_range(0, 1));
      br_off     = 8'($urandom_range(0, 255));
    end
    #1;
    if (pc_init)           pcn = 10'd0;
    else if (pc_branch_en) pcn = pc_bsign ? pc - {2'b00, pc_boffset} : pc + {2'b00, pc_boffset};
    else                   pcn = pc + 10'd1;
    fin = fi;
    fcn = fcyc;
    if (imem_req) begin
      if (imem_ack) begin fin = fi + 1; fcn = 0; end
      else fcn = fcyc + 1;
    end
    @(posedge CLK);
    #1;
    pc   = pcn;
    fi   = fin;
    fcyc = fcn;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc_init"}, 32'(pc_init), 1);
    chk({tag, "_branch_en"}, 32'(pc_branch_en), 0);
    chk({tag, "_bsign"}, 32'(pc_bsign), 0);
    chk({tag, "_boffset"}, 32'(pc_boffset), 0);
    chk({tag, "_imem_req"}, 32'(imem_req), 0);
    chk({tag, "_ir_load"}, 32'(ir_load), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_fault"}, 32'(fault), 0);
    chk({tag, "_instr_cnt"}, 32'(instr_cnt), 0);
  endtask

  // Runs the loaded program from IDLE to its end and back to IDLE at pc 0.
  task automatic run_prog(input string tag);
    int cyc = 0;
    model();
    fi = 0;
    fcyc = 0;
    step(1'b1);
    chk({tag, "_start_fetch"}, 32'(imem_req), 1);
    chk({tag, "_cnt_clear"}, 32'(instr_cnt), 0);
    while (!done && !fault && cyc < 3000) begin
      step(1'b0);
      cyc++;
    end
    if (cyc >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_end: no done/fault within %0d cycles", tag, cyc);
    end
    repeat (3) step(1'b0);
    chk({tag, "_held_pc"}, 32'(pc), 32'(last_term.pc));
    chk({tag, "_held_status"}, {30'd0, done, fault}, (last_term.kind == 1) ? 32'd2 : 32'd1);
    chk({tag, "_queues_drained"}, 32'(exp_fetch.size() + exp_term.size()), 0);
    exp_fetch.delete();
    exp_term.delete();
    step(1'b1);
    step(1'b0);
    chk({tag, "_idle_pc"}, 32'(pc), 0);
    chk({tag, "_idle_init"}, 32'(pc_init), 1);
  endtask

  // Scoreboard monitor: pops an expected fetch pc on each ir_load and an
  // expected end-of-run record when done or fault rises.
  initial begin : monitor
    term_t t;
    forever begin
      @(negedge CLK);
      #2;
      if (ir_load) begin
        if (exp_fetch.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL fetch_pc: unexpected ir_load at pc %0d", pc);
        end else begin
          chk("fetch_pc", 32'(pc), 32'(exp_fetch.pop_front()));
        end
      end
      if ((done && !prev_done) || (fault && !prev_fault)) begin
        if (exp_term.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL term: unexpected done=%0d fault=%0d", done, fault);
        end else begin
          t = exp_term.pop_front();
          chk("term_kind", done ? 32'd1 : 32'd2, 32'(t.kind));
          chk("term_pc", 32'(pc), 32'(t.pc));
          chk("term_cnt", 32'(instr_cnt), 32'(t.cnt));
        end
      end
      chk("status_exclusive", 32'(int'(busy) + int'(done) + int'(fault) <= 1), 1);
      chk("ir_load_outside_fetch", 32'(ir_load && !imem_req), 0);
      prev_done  = done;
      prev_fault = fault;
    end
  end

  initial begin : stimulus
    #1;
    check_reset_outputs("por");
    @(negedge CLK);
    init_n = 1'b1;
    #1;
    chk("post_release_idle", 32'(pc_init), 1);
    step(1'b0);
    step(1'b0);
    check_reset_outputs("idle");

    // Straight-line program to the last PC.
    clear_prog();
    run_prog("seq");

    // Branch back by 4 at pc 10, then out-of-range forward branch at pc 6.
    clear_prog();
    prog[10] = '{1'b0, 1'b1, 1'b1, 8'd4, 0};
    prog[11] = '{1'b0, 1'b1, 1'b0, 8'd60, 0};
    run_prog("branch");

    // Acknowledge withheld for the full timeout, then granted on the last cycle.
    clear_prog();
    prog[3].delay = 15;
    run_prog("timeout");
    clear_prog();
    prog[3].delay = 14;
    prog[4].halt  = 1'b1;
    run_prog("late_ack");

    // Halt beats a simultaneous branch.
    clear_prog();
    prog[5] = '{1'b1, 1'b1, 1'b1, 8'd2, 0};
    run_prog("halt_prio");

    // Zero-offset branch refetches the same pc.
    clear_prog();
    prog[2] = '{1'b0, 1'b1, 1'b0, 8'd0, 1};
    prog[3].halt = 1'b1;
    run_prog("br_zero");

    // Branch exactly onto LAST_PC, back exactly to 0, then below 0.
    clear_prog();
    prog[0] = '{1'b0, 1'b1, 1'b0, 8'd63, 0};
    prog[1] = '{1'b0, 1'b1, 1'b1, 8'd63, 2};
    prog[2] = '{1'b0, 1'b1, 1'b1, 8'd1, 0};
    run_prog("br_edges");

    for (int r = 0; r < 25; r++) begin
      random_prog();
      run_prog($sformatf("rand%0d", r));
    end

    // Asynchronous reset in the middle of EXEC, between clock edges.
    clear_prog();
    model();
    fi = 0;
    fcyc = 0;
    step(1'b1);
    for (int c = 0; c < 200 && !(fi >= 6 && busy && !imem_req); c++) step(1'b0);
    chk("pre_reset_in_exec", 32'(busy && !imem_req), 1);
    #1;
    init_n = 1'b0;
    #1;
    check_reset_outputs("async");
    exp_fetch.delete();
    exp_term.delete();
    @(negedge CLK);
    init_n = 1'b1;
    fi = 0;
    fcyc = 0;
    #1;
    chk("release_no_edge_idle", 32'(pc_init), 1);
    step(1'b0);
    check_reset_outputs("after_release");

    // Normal operation resumes after the reset.
    clear_prog();
    prog[7].halt = 1'b1;
    run_prog("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
